// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// sequencer state type, the default memory size and a helper that turns a
// size code into a byte count.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MEM_LEN_DEF = 65000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bytes moved for a size code; 0 marks the illegal encoding.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_to_bytes = 3'd1;
      SZ_HALF: size_to_bytes = 3'd2;
      SZ_WORD: size_to_bytes = 3'd4;
      default: size_to_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational zero/sign extension of an assembled load.
// Ports:
//   acc       - little-endian assembled bytes (only the low 8n bits are meaningful)
//   size      - size code of the load
//   is_signed - 1: replicate bit 8n-1 upward, 0: fill with zeros
//   ext       - extended result
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] ext
);

  function automatic logic [DATA_W-1:0] extend_byte(input logic [DATA_W-1:0] v, input logic sg);
    logic signed [7:0] b;
    b = v[7:0];
    if (sg) extend_byte = DATA_W'(b);
    else    extend_byte = {{(DATA_W-8){1'b0}}, v[7:0]};
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(input logic [DATA_W-1:0] v, input logic sg);
    logic signed [15:0] h;
    h = v[15:0];
    if (sg) extend_half = DATA_W'(h);
    else    extend_half = {{(DATA_W-16){1'b0}}, v[15:0]};
  endfunction

  always_comb begin
    ext = acc;
    case (size)
      SZ_BYTE: ext = extend_byte(acc, is_signed);
      SZ_HALF: ext = extend_half(acc, is_signed);
      default: ext = acc;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bridges a CPU request/response port to a byte-wide
// memory (combinational read, synchronous write). Each accepted request is
// split into one byte access per cycle, least-significant byte first.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                  - request fields
//   resp_valid, resp_err,
//   resp_rdata                 - one-cycle completion pulse with status/data
//   mem_addr, mem_wdata,
//   mem_we, mem_rdata          - byte memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LEN = MEM_LEN_DEF,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic              lat_write, lat_signed, lat_err;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_acc;
  logic [DATA_W-1:0] ext_data;

  logic [2:0]        req_n;
  logic [ADDR_W:0]   last_addr;
  logic              req_bad;
  logic [2:0]        lat_n;
  logic [1:0]        last_cnt;
  logic              accept;

  // Range check is done one bit wider than the address so that a request
  // running past the top of the address space cannot wrap back in range.
  assign req_n     = size_to_bytes(req_size);
  assign last_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_n) - {{ADDR_W{1'b0}}, 1'b1};
  assign req_bad   = (req_n == 3'd0) || (last_addr >= (ADDR_W+1)'(MEM_LEN));
  assign accept    = (state == IDLE) && req_valid;

  assign lat_n    = size_to_bytes(lat_size);
  assign last_cnt = 2'(lat_n - 3'd1);

  // Control state: the only registers that reset needs to touch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      lat_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_err <= req_bad;
        cnt     <= 2'd0;
      end else if (state == XFER) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Request payload and load assembly; always qualified by state, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_size   <= req_size;
      lat_signed <= req_signed;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
      rdata_acc  <= '0;
    end else if ((state == XFER) && !lat_write) begin
      rdata_acc[{cnt, 3'b000} +: 8] <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_bad ? DONE : XFER;
      XFER:    if (cnt == last_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lsu_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .acc      (rdata_acc),
    .size     (lat_size),
    .is_signed(lat_signed),
    .ext      (ext_data)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_err   = (state == DONE) && lat_err;
  assign resp_rdata = ((state == DONE) && !lat_err && !lat_write) ? ext_data : '0;

  // Memory port is held at zero during reset so an interrupted store cannot
  // land one more byte on the reset edge.
  assign mem_we    = (state == XFER) && lat_write && !reset;
  assign mem_addr  = ((state == XFER) && !reset) ? (lat_addr + ADDR_W'(cnt)) : '0;
  assign mem_wdata = ((state == XFER) && lat_write && !reset) ? lat_wdata[{cnt, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .resp_rdata(resp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Byte memory: combinational read, synchronous write.
  logic [7:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  int cyc = 0;
  int we_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every response must match the oldest outstanding expectation.
  // Latency is counted in edges from the accept edge to the DONE cycle.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got resp_valid=1 err=%0b rdata=0x%08h expected no response", resp_err, resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_err", 32'(resp_err), 32'(mon_e.err));
        chk("resp_rdata", resp_rdata, mon_e.rd);
        chk("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0: nbytes = 1;
      2'd1: nbytes = 2;
      2'd2: nbytes = 4;
      default: nbytes = 0;
    endcase
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [15:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input bit exp_resp, input bit hold, output int acc);
    int t;
    exp_t e;
    @(negedge clk);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    acc = cyc + 1;
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else if (exp_resp) begin
      e.err = exp_err;
      e.rd  = exp_rd;
      e.lat = exp_err ? 0 : nbytes(sz);
      e.acc = acc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d outstanding responses expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog");
  end

  int a0, a1, a2, we0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];

    // Reset held two cycles while a store is offered.
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 16'h0537;
    req_wdata  = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_write_count", 32'(we_count), 32'd0);
    chk("rst_mem_0537", 32'(mem[16'h0537]), 32'h37);

    // Word store then immediate word load of the same address.
    issue(1'b1, 2'd2, 1'b0, 16'h0100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd2, 1'b0, 16'h0100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, a1);
    drain();
    chk("mem_0100", 32'(mem[16'h0100]), 32'hEF);
    chk("mem_0101", 32'(mem[16'h0101]), 32'hBE);
    chk("mem_0102", 32'(mem[16'h0102]), 32'hAD);
    chk("mem_0103", 32'(mem[16'h0103]), 32'hDE);

    // Misaligned half store, signed/unsigned half loads, signed byte load.
    issue(1'b1, 2'd1, 1'b0, 16'h0201, 32'h000080FF, 1'b0, 32'h0,        1'b1, 1'b0, a0);
    issue(1'b0, 2'd1, 1'b1, 16'h0201, 32'h0,        1'b0, 32'hFFFF80FF, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd1, 1'b0, 16'h0201, 32'h0,        1'b0, 32'h000080FF, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd0, 1'b1, 16'h0202, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd0, 1'b0, 16'h0202, 32'h0,        1'b0, 32'h00000080, 1'b1, 1'b0, a0);
    drain();

    // Range checks: last valid byte is 64999.
    we0 = we_count;
    issue(1'b0, 2'd2, 1'b0, 16'd64996, 32'h0, 1'b0, 32'hE7E6E5E4, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd2, 1'b0, 16'd64997, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd2, 1'b0, 16'd64998, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, a0);
    issue(1'b1, 2'd2, 1'b0, 16'd64998, 32'h12345678, 1'b1, 32'h0, 1'b1, 1'b0, a0);
    issue(1'b1, 2'd0, 1'b0, 16'd65535, 32'h000000AA, 1'b1, 32'h0, 1'b1, 1'b0, a0);
    issue(1'b1, 2'd3, 1'b0, 16'h0010, 32'h55555555, 1'b1, 32'h0, 1'b1, 1'b0, a0);
    drain();
    chk("err_no_mem_write", 32'(we_count), 32'(we0));
    chk("mem_fde6_untouched", 32'(mem[16'd64998]), 32'hE6);
    issue(1'b1, 2'd0, 1'b0, 16'd64999, 32'h0000005C, 1'b0, 32'h0, 1'b1, 1'b0, a0);
    issue(1'b0, 2'd0, 1'b0, 16'd64999, 32'h0,        1'b0, 32'h0000005C, 1'b1, 1'b0, a0);
    drain();
    chk("top_byte_write_count", 32'(we_count), 32'(we0 + 1));

    // Reset during the third byte of a word store.
    issue(1'b1, 2'd2, 1'b0, 16'h0300, 32'h11223344, 1'b0, 32'h0, 1'b0, 1'b0, a0);
    for (int t = 0; t < 10 && cyc != a0 + 2; t++) @(negedge clk);
    chk("midreset_cycle", 32'(cyc), 32'(a0 + 2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("mem_0300", 32'(mem[16'h0300]), 32'h44);
    chk("mem_0301", 32'(mem[16'h0301]), 32'h33);
    chk("mem_0302", 32'(mem[16'h0302]), 32'h02);
    chk("mem_0303", 32'(mem[16'h0303]), 32'h03);

    // Back-to-back byte stores with req_valid held high.
    issue(1'b1, 2'd0, 1'b0, 16'h0400, 32'h000000A1, 1'b0, 32'h0, 1'b1, 1'b1, a0);
    issue(1'b1, 2'd0, 1'b0, 16'h0401, 32'h000000A2, 1'b0, 32'h0, 1'b1, 1'b1, a1);
    issue(1'b1, 2'd0, 1'b0, 16'h0402, 32'h000000A3, 1'b0, 32'h0, 1'b1, 1'b0, a2);
    drain();
    chk("b2b_gap1", 32'(a1 - a0), 32'd3);
    chk("b2b_gap2", 32'(a2 - a1), 32'd3);
    chk("mem_0400", 32'(mem[16'h0400]), 32'hA1);
    chk("mem_0401", 32'(mem[16'h0401]), 32'hA2);
    chk("mem_0402", 32'(mem[16'h0402]), 32'hA3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
